coproc_hub: RTL and testbench
=============================

# coproc_hub

Parametrised multi-channel coprocessor bridge between the 32-bit processor bus word and up to CH attached compute modules. It decodes addressed request words, dispatches payloads to per-channel modules with busy tracking, collects their results through per-channel capture registers and a shared response FIFO, and raises an interrupt while results are waiting. It supersedes the single-channel bridge, which held only one result and overwrote it unconditionally.

## Interface
Parameters:
- ADDR_W, 2: device address field width (bus word MSBs)
- CMD_W, 6: command field width
- DATA_W, 24: payload width; bus word width BUS_W = ADDR_W+CMD_W+DATA_W (32 at defaults)
- CH, 2: number of module channels, 1..2^(CMD_W)-3, and 3*CH+clog2(FIFO_DEPTH)+1 ≤ DATA_W
- FIFO_DEPTH, 4: response FIFO entries, power of two ≥2
- IRQ_LEVEL, 1: 1 = irq is a level (FIFO non-empty); 0 = one-cycle pulse per push

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- devaddrin  in  ADDR_W  address this hub answers on the request bus
- devaddrout  in  ADDR_W  source address stamped into response words
- in  in  BUS_W  request word {addr, cmd, data}; each request valid for exactly one cycle
- out  out  BUS_W  response/status word, registered, held until next pop/status
- mstart  out  CH  one-hot start pulse, registered
- min  out  DATA_W  payload for the started channel, registered, shared by all channels
- mrdy  in  CH  per-channel one-cycle result strobe
- mout  in  CH*DATA_W  per-channel result, channel c at [c*DATA_W +: DATA_W], valid with mrdy[c]
- irq  out  1  interrupt, registered

## Operation
- Request accepted when in[BUS_W-1 -: ADDR_W] == devaddrin; cmd = next CMD_W bits, data = low DATA_W bits. CMD_ALL1 = all ones.
- cmd < CH, START: if busy[cmd]==0, mstart[cmd]=1 and min=data next cycle, busy[cmd] set; if busy, request dropped and err[cmd] set.
- cmd == CMD_ALL1, POP: non-empty → out <= {1'b1, devaddrout, channel index zero-extended to CMD_W-1 bits, data}, entry removed; empty → out <= 0.
- cmd == CMD_ALL1-1, FLUSH: FIFO count and all pending flags cleared; busy and err unchanged.
- cmd == CMD_ALL1-2, STATUS: out <= {1'b0, devaddrout, (CMD_W-1)'b0, data field}; data field LSB-first: busy[CH-1:0], err[CH-1:0], pending[CH-1:0], count (clog2(FIFO_DEPTH)+1 bits), zero above. All err cleared in the same cycle.
- Other cmd values: ignored, no state change.
- mrdy[c]: mout slice latched into cap[c], pending[c] set, busy[c] cleared. If pending[c] already set, new data overwrites cap[c] and err[c] set.
- Push arbiter: each cycle, lowest-index c with pending[c] pushes {c, cap[c]} if FIFO not full (count < FIFO_DEPTH) or a POP removes an entry in the same cycle; pending[c] cleared. One push per cycle max.
- FIFO full: pending entries wait; no data loss except capture overwrite.
- Simultaneous: push+pop → count unchanged, pop returns oldest entry (never the one being pushed when count was 0; pop on empty returns 0). FLUSH + mrdy same cycle → flush applied, new mrdy still captured. FLUSH wins over a same-cycle push. mrdy[c] same cycle as pending[c] being pushed → old entry pushed, new data captured, no err.
- irq: IRQ_LEVEL=1 → irq = (next count != 0); IRQ_LEVEL=0 → irq = 1 for one cycle per push.

## Timing
- Reset values: out=0, mstart=0, min=0, irq=0; count=0, FIFO pointers 0, busy/pending/err=0. Reset mid-operation discards everything; mrdy during reset ignored.
- START in cycle N → mstart/min valid cycle N+1 (1-cycle pulse); busy visible in STATUS from N+1.
- mrdy[c] in cycle N → pending[c] at N+1 → push at edge ending N+1 (if winning, not full) → count/irq updated in cycle N+2.
- POP in cycle M → out valid cycle M+1; count decremented M+1; level irq falls M+1 if last entry.
- STATUS snapshot reflects register values in the request cycle.
- Back-to-back requests every cycle supported.

## Test plan
- Reset: assert rst 2 cycles with in addressed → out=0, mstart=0, irq=0, STATUS returns data 0.
- START ch0 data 0x00ABCD → mstart=2'b01, min=0x00ABCD at N+1; mrdy[0] mout=0x123456 → irq high at N+2; POP → out=0x80123456 (devaddrout=0, ch0), irq low next cycle.
- Simultaneous mrdy[0]=0x111111, mrdy[1]=0x222222 → two pops return ch0 then ch1 (0x80111111, 0x81222222).
- Fill FIFO (4 results) plus 1 more → 5th stays pending, irq high; POP frees slot, pending pushed same cycle; 5 POPs return in order, 6th POP → out=0.
- START ch1 twice without mrdy → one mstart pulse, STATUS shows busy[1]=1, err[1]=1; second STATUS shows err cleared.
- FLUSH with 3 entries and mrdy[0] same cycle → count becomes 1 (new capture only after push), IRQ_LEVEL=0 build shows exactly one irq pulse per push.

Source files
------------

// File: rtl/coproc_hub.sv
// coproc_hub: multi-channel coprocessor bridge. Decodes addressed bus requests, dispatches
// payloads to compute channels, captures their results and queues them in a response FIFO.

module coproc_hub_lane #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_req,
    input  logic              mrdy,
    input  logic [DATA_W-1:0] mout,
    input  logic              push_sel,
    input  logic              flush,
    input  logic              err_clr,
    output logic              busy,
    output logic              pending,
    output logic              err,
    output logic [DATA_W-1:0] cap
);
    logic start_ok, start_drop, overwrite;

    assign start_ok   = start_req & ~busy;
    assign start_drop = start_req & busy;
    // a new result landing while the old one leaves through the arbiter loses nothing
    assign overwrite  = mrdy & pending & ~push_sel & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            pending <= 1'b0;
            err     <= 1'b0;
            cap     <= '0;
        end else begin
            busy    <= start_ok | (busy & ~mrdy);
            pending <= mrdy | (pending & ~push_sel & ~flush);
            err     <= start_drop | overwrite | (err & ~err_clr);
            if (mrdy)
                cap <= mout;
        end
    end
endmodule

module coproc_hub #(
    parameter int ADDR_W     = 2,
    parameter int CMD_W      = 6,
    parameter int DATA_W     = 24,
    parameter int CH         = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int IRQ_LEVEL  = 1,
    localparam int BUS_W     = ADDR_W + CMD_W + DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    devaddrin,
    input  logic [ADDR_W-1:0]    devaddrout,
    input  logic [BUS_W-1:0]     in,
    output logic [BUS_W-1:0]     out,
    output logic [CH-1:0]        mstart,
    output logic [DATA_W-1:0]    min,
    input  logic [CH-1:0]        mrdy,
    input  logic [CH*DATA_W-1:0] mout,
    output logic                 irq
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int IDXO_W = CMD_W - 1;
    localparam int ENT_W  = IDX_W + DATA_W;

    localparam logic [CMD_W-1:0] CMD_POP    = '1;
    localparam logic [CMD_W-1:0] CMD_FLUSH  = CMD_POP - CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_STATUS = CMD_POP - CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_CH     = CMD_W'(CH);

    // request decode
    logic              hit;
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
    logic              is_start, is_pop, is_flush, is_status;

    assign hit       = (in[BUS_W-1 -: ADDR_W] == devaddrin);
    assign cmd       = in[DATA_W +: CMD_W];
    assign data      = in[DATA_W-1:0];
    assign is_start  = hit && (cmd < CMD_CH);
    assign is_pop    = hit && (cmd == CMD_POP);
    assign is_flush  = hit && (cmd == CMD_FLUSH);
    assign is_status = hit && (cmd == CMD_STATUS);

    // per-channel state
    logic [CH-1:0]             start_req, busy, pending, err, push_sel;
    logic [CH-1:0][DATA_W-1:0] cap;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        assign start_req[c] = is_start && (cmd == CMD_W'(c));

        coproc_hub_lane #(.DATA_W(DATA_W)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .start_req (start_req[c]),
            .mrdy      (mrdy[c]),
            .mout      (mout[c*DATA_W +: DATA_W]),
            .push_sel  (push_sel[c]),
            .flush     (is_flush),
            .err_clr   (is_status),
            .busy      (busy[c]),
            .pending   (pending[c]),
            .err       (err[c]),
            .cap       (cap[c])
        );
    end

    // response FIFO
    logic [FIFO_DEPTH-1:0][ENT_W-1:0] mem;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              full, pop_ok;
    logic [ENT_W-1:0]  rd_ent;

    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign pop_ok = is_pop && (count != '0);
    assign rd_ent = mem[rd_ptr];

    // lowest pending channel wins; a same-cycle pop makes room even when full
    logic             push_any, push_en;
    logic [IDX_W-1:0] push_idx;

    always_comb begin
        push_any = 1'b0;
        push_idx = '0;
        for (int c = 0; c < CH; c++) begin
            if (pending[c] && !push_any) begin
                push_any = 1'b1;
                push_idx = IDX_W'(c);
            end
        end
        push_en  = push_any && !is_flush && (!full || pop_ok);
        push_sel = push_en ? (CH'(1) << push_idx) : '0;
    end

    always_comb begin
        count_nxt = count + CNT_W'(push_en) - CNT_W'(pop_ok);
        if (is_flush)
            count_nxt = '0;
    end

    logic [DATA_W-1:0] status_word;
    assign status_word = DATA_W'({count, pending, err, busy});

    always_ff @(posedge clk) begin
        if (rst) begin
            out    <= '0;
            mstart <= '0;
            min    <= '0;
            irq    <= 1'b0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            mstart <= start_req & ~busy;
            if (|(start_req & ~busy))
                min <= data;

            if (pop_ok)
                out <= {1'b1, devaddrout, IDXO_W'(rd_ent[DATA_W +: IDX_W]), rd_ent[DATA_W-1:0]};
            else if (is_pop)
                out <= '0;
            else if (is_status)
                out <= {1'b0, devaddrout, {IDXO_W{1'b0}}, status_word};

            if (is_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_en)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            irq   <= (IRQ_LEVEL != 0) ? (count_nxt != '0) : push_en;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en)
            mem[wr_ptr] <= {push_idx, cap[push_idx]};
    end
endmodule

// File: tb/tb_coproc_hub.sv
// Bench for coproc_hub: directed steps plus random traffic, every cycle checked against a
// queue-based reference model. A second instance runs the pulse-interrupt build.

module tb_coproc_hub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  devaddrin  = 2'b01;
    logic [1:0]  devaddrout = 2'b00;
    logic [31:0] bus_in = '0;
    logic [1:0]  mrdy = '0;
    logic [47:0] mout = '0;
    logic [31:0] out, out_p;
    logic [1:0]  mstart, mstart_p;
    logic [23:0] min, min_p;
    logic        irq, irq_p;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [5:0] C_POP = 6'd63, C_FLUSH = 6'd62, C_STATUS = 6'd61;
    localparam logic [31:0] IDLE = 32'h0;

    always #5 clk = ~clk;

    coproc_hub #(.IRQ_LEVEL(1)) u_dut (
        .clk(clk), .rst(rst), .devaddrin(devaddrin), .devaddrout(devaddrout),
        .in(bus_in), .out(out), .mstart(mstart), .min(min),
        .mrdy(mrdy), .mout(mout), .irq(irq)
    );

    coproc_hub #(.IRQ_LEVEL(0)) u_dut_p (
        .clk(clk), .rst(rst), .devaddrin(devaddrin), .devaddrout(devaddrout),
        .in(bus_in), .out(out_p), .mstart(mstart_p), .min(min_p),
        .mrdy(mrdy), .mout(mout), .irq(irq_p)
    );

    // reference model state
    logic [31:0] q[$];            // {channel, result} in arrival order
    logic [1:0]  m_busy, m_err, m_pend;
    logic [23:0] m_cap[2];
    logic [31:0] m_out;
    logic [23:0] m_min;
    logic [1:0]  m_ms;
    logic        m_irq, m_irqp;

    function automatic logic [31:0] req(input logic [5:0] c, input logic [23:0] d);
        return {devaddrin, c, d};
    endfunction

    function automatic logic [23:0] status_word();
        return {15'b0, 3'(q.size()), m_pend, m_err, m_busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = '0; m_err = '0; m_pend = '0;
        m_cap[0] = '0; m_cap[1] = '0;
        m_out = '0; m_min = '0; m_ms = '0; m_irq = 1'b0; m_irqp = 1'b0;
    endtask

    task automatic check_all();
        chk("out", out, m_out);
        chk("mstart", 32'(mstart), 32'(m_ms));
        chk("min", 32'(min), 32'(m_min));
        chk("irq_level", 32'(irq), 32'(m_irq));
        chk("out_p", out_p, m_out);
        chk("mstart_p", 32'(mstart_p), 32'(m_ms));
        chk("min_p", 32'(min_p), 32'(m_min));
        chk("irq_pulse", 32'(irq_p), 32'(m_irqp));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus_in = req(6'd0, 24'h00F00D);
        mrdy = 2'b11;
        mout = {24'h999999, 24'h888888};
        model_reset();
        repeat (n) begin
            @(posedge clk); #1;
            check_all();
        end
        rst = 1'b0;
        mrdy = '0;
    endtask

    // one bus cycle: drive, predict from the rules, clock, compare
    task automatic step(input logic [31:0] w, input logic [1:0] r,
                        input logic [23:0] d0, input logic [23:0] d1);
        logic       hit, popped, pushed, flush, start_ok;
        logic [5:0] c;
        logic [23:0] d;
        logic [31:0] e;
        int sz0, pc;
        bus_in = w; mrdy = r; mout = {d1, d0};
        hit = (w[31:30] == devaddrin);
        c = w[29:24];
        d = w[23:0];
        flush = hit && (c == C_FLUSH);
        popped = 1'b0; pushed = 1'b0; m_ms = '0; start_ok = 1'b0;
        sz0 = q.size();

        if (hit && c == C_STATUS)
            m_out = {1'b0, devaddrout, 5'b0, status_word()};
        if (hit && c == C_POP) begin
            if (sz0 > 0) begin
                e = q.pop_front();
                m_out = {1'b1, devaddrout, 5'(e[31:24]), e[23:0]};
                popped = 1'b1;
            end else
                m_out = '0;
        end

        pc = -1;
        for (int k = 1; k >= 0; k--)
            if (m_pend[k]) pc = k;
        if (pc >= 0 && !flush && (sz0 < 4 || popped)) begin
            q.push_back({8'(pc), m_cap[pc]});
            m_pend[pc] = 1'b0;
            pushed = 1'b1;
        end
        if (flush) begin
            q.delete();
            m_pend = '0;
        end
        if (hit && c == C_STATUS)
            m_err = '0;

        if (hit && c < 6'd2) begin
            if (!m_busy[c[0]]) begin
                start_ok = 1'b1;
                m_ms[c[0]] = 1'b1;
                m_min = d;
            end else
                m_err[c[0]] = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            if (r[k]) begin
                if (m_pend[k]) m_err[k] = 1'b1;
                m_cap[k] = (k == 0) ? d0 : d1;
                m_pend[k] = 1'b1;
                m_busy[k] = 1'b0;
            end
        end
        if (start_ok) m_busy[c[0]] = 1'b1;

        m_irq  = (q.size() != 0);
        m_irqp = pushed;

        @(posedge clk); #1;
        check_all();
    endtask

    logic [5:0]  rc;
    logic [1:0]  ra, rr;
    logic [31:0] rw;
    int          sel;

    initial begin
        // reset with live request and strobes
        do_reset(2);
        chk("reset_out", out, 32'h0);
        chk("reset_mstart", 32'(mstart), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        step(req(C_STATUS, 24'h0), 2'b00, 24'h0, 24'h0);
        chk("reset_status", out, 32'h0);

        // single start / result / pop
        step(req(6'd0, 24'h00ABCD), 2'b00, 24'h0, 24'h0);
        chk("start_mstart", 32'(mstart), 32'h1);
        chk("start_min", 32'(min), 32'h00ABCD);
        step(IDLE, 2'b01, 24'h123456, 24'h0);
        chk("irq_not_yet", 32'(irq), 32'h0);
        step(IDLE, 2'b00, 24'h0, 24'h0);
        chk("irq_raised", 32'(irq), 32'h1);
        step(req(C_POP, 24'h0), 2'b00, 24'h0, 24'h0);
        chk("pop_first", out, 32'h80123456);
        chk("irq_fall", 32'(irq), 32'h0);

        // simultaneous results on both channels
        step(IDLE, 2'b11, 24'h111111, 24'h222222);
        step(IDLE, 2'b00, 24'h0, 24'h0);
        step(IDLE, 2'b00, 24'h0, 24'h0);
        step(req(C_POP, 24'h0), 2'b00, 24'h0, 24'h0);
        chk("pop_ch0", out, 32'h80111111);
        step(req(C_POP, 24'h0), 2'b00, 24'h0, 24'h0);
        chk("pop_ch1", out, 32'h81222222);

        // fill the FIFO plus one waiting capture
        for (int k = 1; k <= 5; k++)
            step(IDLE, 2'b01, 24'hA00000 + 24'(k), 24'h0);
        step(IDLE, 2'b00, 24'h0, 24'h0);
        step(IDLE, 2'b00, 24'h0, 24'h0);
        chk("full_irq", 32'(irq), 32'h1);
        step(req(C_STATUS, 24'h0), 2'b00, 24'h0, 24'h0);
        chk("full_status", out, 32'h00000110);
        for (int k = 1; k <= 5; k++) begin
            step(req(C_POP, 24'h0), 2'b00, 24'h0, 24'h0);
            chk("fill_pop", out, 32'h80A00000 + 32'(k));
        end
        step(req(C_POP, 24'h0), 2'b00, 24'h0, 24'h0);
        chk("pop_empty", out, 32'h0);

        // double start on a busy channel
        step(req(6'd1, 24'h000001), 2'b00, 24'h0, 24'h0);
        chk("start1_mstart", 32'(mstart), 32'h2);
        step(req(6'd1, 24'h000002), 2'b00, 24'h0, 24'h0);
        chk("start1_drop", 32'(mstart), 32'h0);
        chk("start1_min_kept", 32'(min), 32'h000001);
        step(req(C_STATUS, 24'h0), 2'b00, 24'h0, 24'h0);
        chk("busy_err_status", out, 32'h0000000A);
        step(req(C_STATUS, 24'h0), 2'b00, 24'h0, 24'h0);
        chk("err_cleared", out, 32'h00000002);

        // flush with three entries queued and a same-cycle capture
        step(IDLE, 2'b11, 24'h555555, 24'h666666);
        step(IDLE, 2'b01, 24'h333333, 24'h0);
        step(IDLE, 2'b00, 24'h0, 24'h0);
        step(IDLE, 2'b00, 24'h0, 24'h0);
        step(req(C_STATUS, 24'h0), 2'b00, 24'h0, 24'h0);
        chk("three_queued", out, 32'h000000C0);
        step(req(C_FLUSH, 24'h0), 2'b01, 24'h777777, 24'h0);
        step(IDLE, 2'b00, 24'h0, 24'h0);
        chk("flush_push_pulse", 32'(irq_p), 32'h1);
        step(IDLE, 2'b00, 24'h0, 24'h0);
        step(req(C_STATUS, 24'h0), 2'b00, 24'h0, 24'h0);
        chk("flush_count1", out, 32'h00000040);
        step(req(C_POP, 24'h0), 2'b00, 24'h0, 24'h0);
        chk("flush_survivor", out, 32'h80777777);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 11);
            ra  = devaddrin;
            case (sel)
                0, 1:    rc = 6'd0;
                2, 3:    rc = 6'd1;
                4, 5, 6: rc = C_POP;
                7:       rc = ($urandom_range(0, 2) == 0) ? C_FLUSH : C_POP;
                8:       rc = C_STATUS;
                9:       rc = 6'd5;
                10:      begin rc = C_POP; ra = 2'b10; end
                default: rc = 6'd0;
            endcase
            rw = {ra, rc, 24'($urandom())};
            rr = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            if (ra == devaddrin && (rc == C_FLUSH || rc == C_STATUS)) rr = '0;
            if (ra == devaddrin && rc < 6'd2) rr[rc[0]] = 1'b0;
            step(rw, rr, 24'($urandom()), 24'($urandom()));
        end

        // reset in the middle of traffic discards everything
        do_reset(1);
        step(req(C_STATUS, 24'h0), 2'b00, 24'h0, 24'h0);
        chk("midreset_status", out, 32'h0);
        step(req(C_POP, 24'h0), 2'b00, 24'h0, 24'h0);
        chk("midreset_pop", out, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
